// File: rtl/cim_macro_cal_sequencer.sv
// cim_macro_cal_sequencer: runs a CSR-programmed job of N vectors through the
// macro calculation path (SRAM read -> macro compute -> SRAM write-back).
// Optional abort feature guarded by macro CIM_CAL_SEQ_ABORT_EN.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i, src_addr_i,      job start pulse and job parameters
//   dst_addr_i, len_i         (sampled only when a start is accepted in IDLE)
//   abort_i                   job abort request (only acted on with the macro)
//   busy_o, done_o,           job status: busy, one-cycle completion pulse,
//   processed_o               number of results written in current/last job
//   sram_*                    SRAM request port (read data one cycle after req)
//   cal_req_o, cal_data_o,    macro compute port; result valid CAL_LATENCY
//   cal_result_i              cycles after the cal_req_o cycle
module cim_macro_cal_sequencer #(
  parameter int SRAM_MEM_ADDR_WIDTH  = 12,
  parameter int SRAM_MEM_DATA_WIDTH  = 64,
  parameter int MACRO_CAL_ADDR_WIDTH = 32,
  parameter int MACRO_CAL_DATA_WIDTH = 32,
  parameter int CAL_LATENCY          = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [SRAM_MEM_ADDR_WIDTH-1:0]       src_addr_i,
  input  logic [SRAM_MEM_ADDR_WIDTH-1:0]       dst_addr_i,
  input  logic [15:0]                          len_i,
  input  logic                                 abort_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [15:0]                          processed_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [SRAM_MEM_ADDR_WIDTH-1:0]       sram_addr_o,
  output logic [SRAM_MEM_DATA_WIDTH/8-1:0]     sram_be_o,
  output logic [SRAM_MEM_DATA_WIDTH-1:0]       sram_wdata_o,
  input  logic [SRAM_MEM_DATA_WIDTH-1:0]       sram_rdata_i,
  output logic                                 cal_req_o,
  output logic [MACRO_CAL_ADDR_WIDTH-1:0]      cal_data_o,
  input  logic [MACRO_CAL_DATA_WIDTH-1:0]      cal_result_i
);

  localparam int AW  = SRAM_MEM_ADDR_WIDTH;
  localparam int DW  = SRAM_MEM_DATA_WIDTH;
  localparam int MAW = MACRO_CAL_ADDR_WIDTH;
  localparam int MDW = MACRO_CAL_DATA_WIDTH;
  localparam int CW  = $clog2(CAL_LATENCY + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CAL_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAL,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     idx_q, idx_d;
  logic [15:0]     proc_q, proc_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [MDW-1:0]  res_q, res_d;

  logic [MAW-1:0]  rd_slice;
  logic [DW-1:0]   res_ext;
  logic            abort_hit;

  // Read data to macro input width (slice, or zero-extend if the macro is wider).
  generate
    if (MAW <= DW) begin : g_rd_slice
      assign rd_slice = sram_rdata_i[MAW-1:0];
      if (MAW < DW) begin : g_rd_unused
        logic [DW-MAW-1:0] unused_rdata;
        assign unused_rdata = sram_rdata_i[DW-1:MAW];
      end
    end else begin : g_rd_ext
      assign rd_slice = {{(MAW-DW){1'b0}}, sram_rdata_i};
    end

    // Result to SRAM width (zero-extend or truncate).
    if (MDW >= DW) begin : g_res_trunc
      assign res_ext = res_q[DW-1:0];
      if (MDW > DW) begin : g_res_unused
        logic [MDW-DW-1:0] unused_res;
        assign unused_res = res_q[MDW-1:DW];
      end
    end else begin : g_res_ext
      assign res_ext = {{(DW-MDW){1'b0}}, res_q};
    end
  endgenerate

`ifdef CIM_CAL_SEQ_ABORT_EN
  assign abort_hit = abort_i;
`else
  assign abort_hit = 1'b0;
  logic unused_abort;
  assign unused_abort = abort_i;
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    proc_d       = proc_q;
    wcnt_d       = wcnt_q;
    res_d        = res_q;
    done_o       = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    cal_req_o    = 1'b0;
    cal_data_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          idx_d   = '0;
          proc_d  = '0;
          state_d = (len_i != 16'd0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        sram_req_o  = 1'b1;
        sram_addr_o = src_q + AW'(idx_q);  // wraps modulo 2^AW
        state_d     = S_CAL;
      end
      S_CAL: begin
        cal_req_o  = 1'b1;
        cal_data_o = rd_slice;
        wcnt_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          res_d   = cal_result_i;
          state_d = S_WR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WR: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = dst_q + AW'(idx_q);
        sram_be_o    = '1;
        sram_wdata_o = res_ext;
        proc_d       = proc_q + 16'd1;
        idx_d        = idx_q + 16'd1;
        // 17-bit compare so len=0xFFFF cannot overflow the index.
        state_d      = (({1'b0, idx_q} + 17'd1) < {1'b0, len_q}) ? S_RD : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort only redirects the next state; this cycle's outputs stand, so a
    // WR in the abort cycle still completes and is counted.
    if (abort_hit && (state_q inside {S_RD, S_CAL, S_WAIT, S_WR})) begin
      state_d = S_DONE;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign processed_o = proc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      proc_q  <= '0;
      wcnt_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      proc_q  <= proc_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_cim_macro_cal_sequencer.sv
// Testbench for cim_macro_cal_sequencer: SRAM and macro behavioural models,
// a job-level reference model feeding an expected-event queue, and a monitor
// that checks every observed DUT transaction against that queue.
module tb_cim_macro_cal_sequencer;

  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int P   = 3 + LAT;

  localparam int EV_RD   = 0;
  localparam int EV_CAL  = 1;
  localparam int EV_WR   = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int          kind;
    longint      cyc;
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   len;
  logic          abort;
  logic          busy, done;
  logic [15:0]   processed;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_be;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          cal_req;
  logic [31:0]   cal_data, cal_result;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;
  ev_t    exp_q[$];
  logic [63:0] ref_mem [0:4095];
  logic [63:0] mem     [0:4095];
  logic        load_mem = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cim_macro_cal_sequencer #(
    .SRAM_MEM_ADDR_WIDTH (AW),
    .SRAM_MEM_DATA_WIDTH (DW),
    .MACRO_CAL_ADDR_WIDTH(32),
    .MACRO_CAL_DATA_WIDTH(32),
    .CAL_LATENCY         (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .len_i       (len),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .processed_o (processed),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_be_o   (sram_be),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata),
    .cal_req_o   (cal_req),
    .cal_data_o  (cal_data),
    .cal_result_i(cal_result)
  );

  // Stand-in for the macro's computation.
  function automatic logic [31:0] macro_f(input logic [31:0] x);
    return {x[26:0], x[31:27]} ^ 32'hC3A5_5A3C;
  endfunction

  // SRAM model: read data registered, random garbage when not reading.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else if (sram_req && sram_we) begin
      mem[sram_addr] <= sram_wdata;
    end
    if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
    else                      sram_rdata <= {$urandom, $urandom};
  end

  // Macro model: result valid exactly LAT cycles after cal_req, junk otherwise.
  logic [31:0] pd [LAT];
  logic        pv [LAT];
  logic [31:0] junk;
  always @(posedge clk) begin
    pd[0] <= macro_f(cal_data);
    pv[0] <= cal_req;
    for (int i = 1; i < LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
    junk <= $urandom;
  end
  always_comb cal_result = pv[LAT-1] ? pd[LAT-1] : junk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic see(input int kind, input logic [63:0] a, input logic [63:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d addr %h data %h at cycle %0d, none expected",
               kind, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk("event_cycle", 64'(cyc), 64'(e.cyc));
    chk("event_addr", a, e.a);
    chk("event_data", d, e.d);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (sram_req && !sram_we) see(EV_RD, 64'(sram_addr), 64'd0);
    if (cal_req) see(EV_CAL, 64'd0, 64'(cal_data));
    if (sram_req && sram_we) begin
      see(EV_WR, 64'(sram_addr), sram_wdata);
      chk("wr_be", 64'(sram_be), 64'hFF);
    end
    if (done) begin
      see(EV_DONE, 64'(processed), 64'd0);
      chk("done_busy", 64'(busy), 64'd1);
    end
    if (!sram_req) begin
      chk("idle_sram_ctrl", 64'({sram_we, sram_be, sram_addr}), 64'd0);
      chk("idle_sram_wdata", sram_wdata, 64'd0);
    end
    if (!cal_req) chk("idle_cal_data", 64'(cal_data), 64'd0);
  end

  function automatic bit live(input longint c, input longint lim, input longint rst_c);
    return (c <= lim) && (rst_c == 0 || c < rst_c);
  endfunction

  // Job-level reference: walks the vectors in order against its own memory
  // image and emits the cycle-stamped events the DUT must produce.
  task automatic model_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n,
                           input longint t0, input longint abort_c, input longint rst_c,
                           output longint done_c, output int cnt);
    ev_t e;
    logic [AW-1:0] sa, da;
    logic [31:0] x;
    longint rd, lim;
    cnt = 0;
    lim = 64'h7FFF_FFFF_FFFF;
    if (n == 0) done_c = t0 + 1;
    else        done_c = t0 + n * P + 1;
    if (abort_c > 0 && n > 0 && abort_c >= t0 + 1 && abort_c <= t0 + n * P) begin
      lim    = abort_c;
      done_c = abort_c + 1;
    end
    for (int k = 0; k < n; k++) begin
      rd = t0 + 1 + k * P;
      sa = src + AW'(k);
      da = dst + AW'(k);
      if (!live(rd, lim, rst_c)) break;
      e = '{EV_RD, rd, 64'(sa), 64'd0};
      exp_q.push_back(e);
      x = ref_mem[sa][31:0];
      if (!live(rd + 1, lim, rst_c)) break;
      e = '{EV_CAL, rd + 1, 64'd0, 64'(x)};
      exp_q.push_back(e);
      if (!live(rd + P - 1, lim, rst_c)) break;
      e = '{EV_WR, rd + P - 1, 64'(da), {32'd0, macro_f(x)}};
      exp_q.push_back(e);
      ref_mem[da] = {32'd0, macro_f(x)};
      cnt++;
    end
    if (rst_c == 0 || done_c < rst_c) begin
      e = '{EV_DONE, done_c, 64'(cnt), 64'd0};
      exp_q.push_back(e);
    end
  endtask

  // Offsets are relative to the start cycle; <=0 disables the extra action.
  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n,
                         input int xs_off, input int ab_off, input int rs_off);
    longint t0, done_c, ab_c, rs_c;
    int cnt, end_rel;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; src_addr = src; dst_addr = dst; len = 16'(n);
    ab_c = 0;
`ifdef CIM_CAL_SEQ_ABORT_EN
    if (ab_off > 0) ab_c = t0 + ab_off;
`endif
    rs_c = (rs_off > 0) ? t0 + rs_off : 0;
    model_job(src, dst, n, t0, ab_c, rs_c, done_c, cnt);
    end_rel = (rs_off > 0) ? rs_off : int'(done_c - t0) + 1;
    for (int c = 1; c <= end_rel; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      src_addr = AW'($urandom); dst_addr = AW'($urandom); len = 16'($urandom_range(1, 9));
      if (c == xs_off) start = 1'b1;
      if (c == ab_off) abort = 1'b1;
      if (c == rs_off) rst = 1'b1;
    end
    if (rs_off > 0) begin
      #1;
      chk("reset_outputs_ctrl", 64'({busy, done, sram_req, sram_we, sram_be, cal_req}), 64'd0);
      chk("reset_outputs_bus", 64'({sram_addr, processed, cal_data}), 64'd0);
      chk("reset_outputs_wdata", sram_wdata, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_processed", 64'(processed), 64'd0);
    end else begin
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("processed_final", 64'(processed), 64'(cnt));
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] v;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 4096; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
    end
    ref_mem[12'h010] = 64'h0000_0000_1234_5678;
    load_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1 load_mem = 1'b0;
    chk("reset_state_ctrl", 64'({busy, done, sram_req, sram_we, sram_be, cal_req}), 64'd0);
    chk("reset_state_bus", 64'({sram_addr, processed, cal_data}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'd0);
    end

    run_job(12'h010, 12'h020, 1, -1, -1, -1);   // single vector
    run_job(12'hFFE, 12'h100, 4, -1, -1, -1);   // address wrap
    run_job(12'h300, 12'h400, 0, -1, -1, -1);   // zero length
    run_job(12'h200, 12'h280, 3,  4, -1, -1);   // ignored start mid-job
    run_job(12'h500, 12'h600, 2, 11, -1, -1);   // start during DONE ignored
    run_job(12'h700, 12'h780, 5, -1, 13, -1);   // abort in WAIT of vector 2
    run_job(12'h800, 12'h880, 4, -1, -1, 10);   // reset during WR of vector 1
    run_job(12'h810, 12'h890, 2, -1, -1, -1);   // clean restart

    for (int j = 0; j < 24; j++) begin
      n = $urandom_range(0, 5);
      run_job(AW'($urandom), AW'($urandom), n,
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * P + 1) : -1,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * P + 1) : -1,
              ($urandom_range(0, 7) == 0 && n > 0) ? $urandom_range(1, n * P) : -1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
